// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch flush,
// multi-cycle data-memory handshake and a saturating stall-cycle counter.
//
// state   | meaning
// IDLE    | no memory op in flight; a MEM-stage load/store stalls and starts a request
// WAIT    | request held to data memory until the ack pulse
// RELEASE | one free cycle so the completed op leaves EX_MEM before memop is re-examined
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] if_id_rs_i,
    input  logic [REG_AW-1:0] if_id_rt_i,
    input  logic              if_id_uses_rt_i,
    input  logic              id_ex_memread_i,
    input  logic [REG_AW-1:0] id_ex_rt_i,
    input  logic              branch_taken_i,
    input  logic              ex_mem_memread_i,
    input  logic              ex_mem_memwrite_i,
    input  logic              dmem_ack_i,
    input  logic              clr_cnt_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_write_o,
    output logic              id_ex_bubble_o,
    output logic              ex_mem_write_o,
    output logic              mem_wb_write_o,
    output logic              dmem_req_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_memop;
    logic             w_mem_stall;
    logic             w_hazard;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_memop = ex_mem_memread_i | ex_mem_memwrite_i;

    assign w_hazard = id_ex_memread_i && (id_ex_rt_i != '0) &&
                      ((id_ex_rt_i == if_id_rs_i) ||
                       (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_memop) w_state_nxt = ST_WAIT;
            ST_WAIT:    if (dmem_ack_i) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mem_stall = 1'b0;
        dmem_req_o  = 1'b0;
        case (r_state)
            ST_IDLE: w_mem_stall = w_memop;
            ST_WAIT: begin
                w_mem_stall = 1'b1;
                dmem_req_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // Priority: memory stall, then load-use interlock, then branch flush.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        ex_mem_write_o = 1'b1;
        mem_wb_write_o = 1'b1;
        if (w_mem_stall) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            mem_wb_write_o = 1'b0;
        end else if (w_hazard) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            r_stall_cnt <= '0;
        end else if (!pc_write_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-width instance and a 4-bit counter
// instance share the same stimulus; control outputs are compared as one packed word.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       if_id_uses_rt, id_ex_memread, branch_taken;
    logic       ex_mem_memread, ex_mem_memwrite, dmem_ack, clr_cnt;

    logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w, req;
    logic [15:0] cnt;
    logic        pc_w4, ifid_w4, ifid_f4, idex_w4, idex_b4, exmem_w4, memwb_w4, req4;
    logic [3:0]  cnt4;

    logic [7:0] ctl;
    int pass_cnt = 0;
    int total    = 0;
    int exp_cnt  = 0;

    // {pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble, ex_mem_w, mem_wb_w, req}
    localparam logic [7:0] C_DEF   = 8'b11010110;
    localparam logic [7:0] C_HAZ   = 8'b00011110;
    localparam logic [7:0] C_BR    = 8'b11110110;
    localparam logic [7:0] C_MSTL  = 8'b00000000;
    localparam logic [7:0] C_WAIT  = 8'b00000001;

    assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w, req};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .if_id_uses_rt_i(if_id_uses_rt),
        .id_ex_memread_i(id_ex_memread), .id_ex_rt_i(id_ex_rt), .branch_taken_i(branch_taken),
        .ex_mem_memread_i(ex_mem_memread), .ex_mem_memwrite_i(ex_mem_memwrite),
        .dmem_ack_i(dmem_ack), .clr_cnt_i(clr_cnt),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(ifid_f),
        .id_ex_write_o(idex_w), .id_ex_bubble_o(idex_b), .ex_mem_write_o(exmem_w),
        .mem_wb_write_o(memwb_w), .dmem_req_o(req), .stall_cycles_o(cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .if_id_uses_rt_i(if_id_uses_rt),
        .id_ex_memread_i(id_ex_memread), .id_ex_rt_i(id_ex_rt), .branch_taken_i(branch_taken),
        .ex_mem_memread_i(ex_mem_memread), .ex_mem_memwrite_i(ex_mem_memwrite),
        .dmem_ack_i(dmem_ack), .clr_cnt_i(clr_cnt),
        .pc_write_o(pc_w4), .if_id_write_o(ifid_w4), .if_id_flush_o(ifid_f4),
        .id_ex_write_o(idex_w4), .id_ex_bubble_o(idex_b4), .ex_mem_write_o(exmem_w4),
        .mem_wb_write_o(memwb_w4), .dmem_req_o(req4), .stall_cycles_o(cnt4)
    );

    // Advance one clock; inputs are then driven at posedge+1, outputs sampled at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
        if_id_uses_rt = 1'b0; id_ex_memread = 1'b0; branch_taken = 1'b0;
        ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; dmem_ack = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        settle();
        total++; if (ctl !== C_DEF) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        total++; if (cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else pass_cnt++;
        tick();
        total++; if (cnt !== 16'd0) $display("FAIL reset_cnt_idle got=%0d exp=0", cnt); else pass_cnt++;
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; settle();
        total++; if (ctl !== C_HAZ) $display("FAIL lu_rs got=%b exp=%b", ctl, C_HAZ); else pass_cnt++;
        tick(); exp_cnt++;
        id_ex_rt = 5'd0; if_id_rs = 5'd0; settle();
        total++; if (ctl !== C_DEF) $display("FAIL lu_r0 got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        total++; if (cnt !== 16'(exp_cnt)) $display("FAIL lu_cnt got=%0d exp=%0d", cnt, exp_cnt); else pass_cnt++;
        tick();
        id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7; if_id_uses_rt = 1'b1; settle();
        total++; if (ctl !== C_HAZ) $display("FAIL lu_rt got=%b exp=%b", ctl, C_HAZ); else pass_cnt++;
        branch_taken = 1'b1; settle();
        total++; if (ctl !== C_HAZ) $display("FAIL lu_branch got=%b exp=%b", ctl, C_HAZ); else pass_cnt++;
        tick(); exp_cnt++;
        branch_taken = 1'b0; if_id_uses_rt = 1'b0; settle();
        total++; if (ctl !== C_DEF) $display("FAIL lu_no_rt got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        id_ex_memread = 1'b0; if_id_uses_rt = 1'b1; settle();
        total++; if (ctl !== C_DEF) $display("FAIL lu_no_load got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        tick();
        idle_inputs(); settle();
        total++; if (cnt !== 16'(exp_cnt)) $display("FAIL lu_cnt2 got=%0d exp=%0d", cnt, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_store_wait();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0; exp_cnt = 0;
        ex_mem_memwrite = 1'b1; settle();
        total++; if (ctl !== C_MSTL) $display("FAIL st_idle got=%b exp=%b", ctl, C_MSTL); else pass_cnt++;
        tick();
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            settle();
            total++; if (ctl !== C_WAIT) $display("FAIL st_wait%0d got=%b exp=%b", i, ctl, C_WAIT); else pass_cnt++;
            tick();
        end
        dmem_ack = 1'b0; branch_taken = 1'b0; settle();
        total++; if (ctl !== C_DEF) $display("FAIL st_release got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        total++; if (cnt !== 16'd5) $display("FAIL st_cnt got=%0d exp=5", cnt); else pass_cnt++;
        tick();
        ex_mem_memwrite = 1'b0; branch_taken = 1'b1; settle();
        total++; if (ctl !== C_BR) $display("FAIL br_flush got=%b exp=%b", ctl, C_BR); else pass_cnt++;
        tick();
        branch_taken = 1'b0; settle();
        total++; if (ctl !== C_DEF) $display("FAIL br_one_cycle got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        total++; if (cnt !== 16'd5) $display("FAIL br_cnt got=%0d exp=5", cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [6];
        exp_seq = '{C_MSTL, C_WAIT, C_DEF, C_MSTL, C_WAIT, C_DEF};
        ex_mem_memread = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_ack = (i == 1 || i == 4);
            settle();
            total++; if (ctl !== exp_seq[i]) $display("FAIL b2b_%0d got=%b exp=%b", i, ctl, exp_seq[i]); else pass_cnt++;
            tick();
        end
        idle_inputs(); settle();
        total++; if (cnt !== 16'd9) $display("FAIL b2b_cnt got=%0d exp=9", cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        ex_mem_memwrite = 1'b1; tick(); settle();
        total++; if (req !== 1'b1) $display("FAIL rw_req got=%b exp=1", req); else pass_cnt++;
        rst = 1'b1; tick();
        rst = 1'b0; ex_mem_memwrite = 1'b0; dmem_ack = 1'b1; settle();
        total++; if (ctl !== C_DEF) $display("FAIL rw_after got=%b exp=%b", ctl, C_DEF); else pass_cnt++;
        total++; if (cnt !== 16'd0) $display("FAIL rw_cnt got=%0d exp=0", cnt); else pass_cnt++;
        tick();
        dmem_ack = 1'b0; ex_mem_memwrite = 1'b1; settle();
        total++; if (ctl !== C_MSTL) $display("FAIL rw_ack_ignored got=%b exp=%b", ctl, C_MSTL); else pass_cnt++;
        tick(); dmem_ack = 1'b1; tick();
        dmem_ack = 1'b0; ex_mem_memwrite = 1'b0; tick();
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        ex_mem_memwrite = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        settle();
        total++; if (cnt4 !== 4'd15) $display("FAIL sat4 got=%0d exp=15", cnt4); else pass_cnt++;
        total++; if (cnt !== 16'd20) $display("FAIL sat16 got=%0d exp=20", cnt); else pass_cnt++;
        total++; if (req4 !== 1'b1) $display("FAIL sat_req got=%b exp=1", req4); else pass_cnt++;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0; settle();
        total++; if (cnt4 !== 4'd0) $display("FAIL clr4 got=%0d exp=0", cnt4); else pass_cnt++;
        total++; if (cnt !== 16'd0) $display("FAIL clr16 got=%0d exp=0", cnt); else pass_cnt++;
        tick();
        total++; if (cnt4 !== 4'd1) $display("FAIL reinc4 got=%0d exp=1", cnt4); else pass_cnt++;
        dmem_ack = 1'b1; tick();
        dmem_ack = 1'b0; ex_mem_memwrite = 1'b0; settle();
        total++; if ({pc_w4, req4} !== 2'b10) $display("FAIL sat_release got=%b exp=10", {pc_w4, req4}); else pass_cnt++;
        total++; if (cnt4 !== 4'd2) $display("FAIL sat_final got=%0d exp=2", cnt4); else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_store_wait();
        test_back_to_back();
        test_reset_mid_wait();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
